// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
//  spi_sram_pkg
//  Shared commands, frame sizes and controller state type.
//  Revision: 1.0
// ============================================================================
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_WRMR   = 8'h01;
    localparam logic [7:0] MODE_SEQ   = 8'h40;
    localparam int         FRAME_BITS = 40;
    localparam int         INIT_BITS  = 16;

    typedef enum logic [2:0] {
        INIT,
        INIT_GAP,
        IDLE,
        SHIFT,
        DONE
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sram_controller_if.sv
`default_nettype none
// ============================================================================
//  spi_sram_controller_if
//  CPU word-access port: level request, one-cycle ready pulse.
//  Revision: 1.0
// ============================================================================
interface spi_sram_controller_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/spi_sram_shifter.sv
`default_nettype none
// ============================================================================
//  spi_sram_shifter
//  Mode-0 SPI bit engine: MSB-first frame out, MISO sampled at end of SCLK high.
//  Revision: 1.0
// ============================================================================
module spi_sram_shifter
    import spi_sram_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [5:0]            nbits_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  miso_i,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic [15:0]           rx_o
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [FRAME_BITS-1:0] sreg_q;
    logic [5:0]            cnt_q;
    logic [DIV_W-1:0]      div_q;
    logic                  sclk_q;
    logic                  busy_q;
    logic [15:0]           rx_q;

    logic half_end;
    logic fall;
    logic finish;

    assign half_end = (div_q == DIV_LAST);
    assign fall     = busy_q && half_end && sclk_q;
    assign finish   = fall && (cnt_q == 6'd1);

    // busy drops during the final cycle so the owner advances on the very edge the frame ends
    assign busy_o = busy_q && !finish;
    assign sclk_o = sclk_q;
    assign mosi_o = sreg_q[FRAME_BITS-1];
    assign rx_o   = rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            div_q  <= '0;
            sclk_q <= 1'b0;
            busy_q <= 1'b0;
            rx_q   <= '0;
        end else if (load_i) begin
            sreg_q <= frame_i;
            cnt_q  <= nbits_i;
            div_q  <= '0;
            sclk_q <= 1'b0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            div_q <= half_end ? '0 : div_q + DIV_W'(1);
            if (half_end) begin
                sclk_q <= ~sclk_q;
            end
            if (fall) begin
                sreg_q <= {sreg_q[FRAME_BITS-2:0], 1'b0};
                rx_q   <= {rx_q[14:0], miso_i};
                cnt_q  <= cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_sram_controller.sv
`default_nettype none
// ============================================================================
//  spi_sram_controller
//  CPU 16-bit word port to 23LC512-class SPI SRAM, one sequential frame per access.
//  Revision: 1.0
// ============================================================================
module spi_sram_controller
    import spi_sram_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          INIT_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_sram_controller_if.slave bus,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam spi_state_t RST_STATE = INIT_MODE ? INIT : IDLE;

    spi_state_t  state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [15:0] rdata_q, rdata_d;

    logic                  sh_load;
    logic [5:0]            sh_nbits;
    logic [FRAME_BITS-1:0] sh_frame;
    logic                  sh_busy;
    logic [15:0]           sh_rx;

    spi_sram_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .nbits_i (sh_nbits),
        .frame_i (sh_frame),
        .miso_i  (spi_miso),
        .busy_o  (sh_busy),
        .sclk_o  (spi_sclk),
        .mosi_o  (spi_mosi),
        .rx_o    (sh_rx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cs_n_d   = cs_n_q;
        ready_d  = 1'b0;
        we_d     = we_q;
        rdata_d  = rdata_q;
        sh_load  = 1'b0;
        sh_nbits = 6'(FRAME_BITS);
        // Data bytes go little-endian; reads clock out zeros while the SRAM answers
        sh_frame = {bus.mem_we ? CMD_WRITE : CMD_READ,
                    bus.mem_addr,
                    bus.mem_we ? bus.mem_wdata[7:0]  : 8'h00,
                    bus.mem_we ? bus.mem_wdata[15:8] : 8'h00};
        case (state_q)
            INIT: begin
                if (cs_n_q) begin
                    sh_load  = 1'b1;
                    sh_nbits = 6'(INIT_BITS);
                    sh_frame = {CMD_WRMR, MODE_SEQ, 24'h000000};
                    cs_n_d   = 1'b0;
                end else if (!sh_busy) begin
                    cs_n_d  = 1'b1;
                    state_d = INIT_GAP;
                end
            end
            INIT_GAP: state_d = IDLE;
            IDLE: begin
                if (bus.mem_req) begin
                    sh_load = 1'b1;
                    we_d    = bus.mem_we;
                    cs_n_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!sh_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cs_n_d  = 1'b1;
                ready_d = 1'b1;
                if (!we_q) begin
                    rdata_d = {sh_rx[7:0], sh_rx[15:8]};
                end
                state_d = IDLE;
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign spi_cs_n      = cs_n_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

endmodule
`default_nettype wire
